// File: rtl/mlp_pkg.sv
// mlp_pkg: shared constants, neuron word type and
// argmax stage state encoding for the MLP datapath.
package mlp_pkg;

  localparam int MLP_DATA_W  = 16;
  localparam int MLP_NUM_OUT = 10;

  typedef logic signed [MLP_DATA_W-1:0] mlp_word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } mlp_state_t;

endpackage

// File: rtl/mlp_signed_gt.sv
// mlp_signed_gt: signed cand > incumb, with an optional
// ReLU pre-stage on cand (macro MLP_ARGMAX_RELU_EN).
module mlp_signed_gt
  import mlp_pkg::*;
#(
  parameter int DATA_W = MLP_DATA_W
) (
  input  logic signed [DATA_W-1:0] cand,
  input  logic signed [DATA_W-1:0] incumb,
  output logic signed [DATA_W-1:0] cand_act,
  output logic                     gt
);

  // Activated candidate: the value that is compared and stored
`ifdef MLP_ARGMAX_RELU_EN
  always_comb begin
    cand_act = cand;
    if (cand[DATA_W-1]) cand_act = '0;
  end
`else
  always_comb begin
    cand_act = cand;
  end
`endif

  // Strict compare so ties keep the earlier index
  always_comb begin
    gt = (cand_act > incumb);
  end

endmodule

// File: rtl/mlp_out_argmax.sv
// mlp_out_argmax: streaming signed argmax over one output
// vector; optional ReLU via macro MLP_ARGMAX_RELU_EN.
module mlp_out_argmax
  import mlp_pkg::*;
#(
  parameter int NUM_OUT = MLP_NUM_OUT,
  parameter int DATA_W  = MLP_DATA_W,
  parameter int IDX_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [IDX_W-1:0]         max_idx,
  output logic signed [DATA_W-1:0] max_val,
  output logic                     len_err
);

  localparam logic [IDX_W:0] LAST_CNT =
    (IDX_W+1)'(NUM_OUT - 1);

  mlp_state_t               state;
  logic [IDX_W:0]           cnt;
  logic signed [DATA_W-1:0] act;
  logic                     gt;
  logic                     accept;
  logic                     last_cnt;
  logic                     end_beat;

  mlp_signed_gt #(
    .DATA_W (DATA_W)
  ) u_gt (
    .cand     (in_data),
    .incumb   (max_val),
    .cand_act (act),
    .gt       (gt)
  );

  // Beat qualification and end-of-vector detection
  always_comb begin
    accept   = in_valid && in_ready;
    last_cnt = (cnt == LAST_CNT);
    end_beat = last_cnt || in_last;
  end

  // FSM, sample counter and registered result fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      max_idx   <= '0;
      max_val   <= '0;
      len_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, COLLECT: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (state == IDLE) begin
              max_val <= act;
              max_idx <= '0;
            end else if (gt) begin
              max_val <= act;
              max_idx <= cnt[IDX_W-1:0];
            end
            cnt <= cnt + 1'b1;
            if (end_beat) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              res_valid <= 1'b1;
              len_err   <= last_cnt ^ in_last;
            end else begin
              state <= COLLECT;
            end
          end
        end
        HOLD: begin
          if (res_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            len_err   <= 1'b0;
            cnt       <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          res_valid <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_out_argmax.sv
// tb_mlp_out_argmax: directed vectors with hand-computed
// argmax results, one task per scenario.
module tb_mlp_out_argmax;
  import mlp_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  mlp_word_t   in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [3:0]  max_idx;
  mlp_word_t   max_val;
  logic        len_err;

  int checks = 0;
  int errors = 0;
  mlp_word_t vec [16];
  logic rv_before;

  mlp_out_argmax dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .max_idx   (max_idx),
    .max_val   (max_val),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic send(input int n, input int last_pos);
    for (int i = 0; i < n; i++) begin
      int budget;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vec[i];
      in_last  = (i == last_pos);
      budget = 0;
      while (!in_ready && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL send_wait in_ready got 0 exp 1 at %0d", i);
      end
      rv_before = res_valid;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic load_mixed();
    vec[0] = 3;  vec[1] = -2; vec[2] = 7; vec[3] = 7;
    vec[4] = 0;  vec[5] = -9; vec[6] = 1; vec[7] = 5;
    vec[8] = 6;  vec[9] = 2;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready got %b exp 0", in_ready);
    end
    checks++;
    if ({res_valid, len_err} !== 2'b00) begin
      errors++;
      $display("FAIL rst_flags got %b%b exp 00", res_valid, len_err);
    end
    checks++;
    if (max_idx !== 4'd0 || max_val !== 16'sd0) begin
      errors++;
      $display("FAIL rst_result got %0d/%0d exp 0/0", max_idx, max_val);
    end
    release_reset();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_mixed();
    load_mixed();
    send(10, 9);
    checks++;
    if (rv_before !== 1'b0 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL mixed_latency got %b->%b exp 0->1", rv_before, res_valid);
    end
    checks++;
    if (max_idx !== 4'd2) begin
      errors++;
      $display("FAIL mixed_idx got %0d exp 2", max_idx);
    end
    checks++;
    if (max_val !== 16'sd7) begin
      errors++;
      $display("FAIL mixed_val got %0d exp 7", max_val);
    end
    checks++;
    if (len_err !== 1'b0) begin
      errors++;
      $display("FAIL mixed_len_err got %b exp 0", len_err);
    end
    ack();
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mixed_ack got rv=%b rdy=%b exp 0 1", res_valid, in_ready);
    end
  endtask

  task automatic test_all_negative();
    logic [3:0] ei;
    mlp_word_t  ev;
    vec[0] = -5;   vec[1] = -3; vec[2] = -8; vec[3] = -3;
    vec[4] = -100; vec[5] = -1; vec[6] = -7; vec[7] = -2;
    vec[8] = -4;   vec[9] = -6;
`ifdef MLP_ARGMAX_RELU_EN
    ei = 4'd0;
    ev = 16'sd0;
`else
    ei = 4'd5;
    ev = -16'sd1;
`endif
    send(10, 9);
    checks++;
    if (max_idx !== ei) begin
      errors++;
      $display("FAIL neg_idx got %0d exp %0d", max_idx, ei);
    end
    checks++;
    if (max_val !== ev) begin
      errors++;
      $display("FAIL neg_val got %h exp %h", max_val, ev);
    end
    ack();
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 10; i++) vec[i] = 0;
    vec[0] = 16'sh8000;
    vec[9] = 16'sh7fff;
    send(10, 9);
    checks++;
    if (max_idx !== 4'd9 || max_val !== 16'sh7fff) begin
      errors++;
      $display("FAIL extremes got %0d/%0d exp 9/32767", max_idx, max_val);
    end
    ack();
  endtask

  task automatic test_short_last();
    vec[0] = 1; vec[1] = 2; vec[2] = 3;
    vec[3] = 9; vec[4] = 4; vec[5] = 5;
    send(6, 5);
    checks++;
    if (res_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL short_hold got rv=%b rdy=%b exp 1 0", res_valid, in_ready);
    end
    checks++;
    if (len_err !== 1'b1) begin
      errors++;
      $display("FAIL short_len_err got %b exp 1", len_err);
    end
    checks++;
    if (max_idx !== 4'd3 || max_val !== 16'sd9) begin
      errors++;
      $display("FAIL short_result got %0d/%0d exp 3/9", max_idx, max_val);
    end
    ack();
  endtask

  task automatic test_no_last();
    for (int i = 0; i < 10; i++) vec[i] = 1;
    vec[0] = 5;
    vec[9] = 8;
    send(10, -1);
    checks++;
    if (res_valid !== 1'b1 || len_err !== 1'b1) begin
      errors++;
      $display("FAIL nolast_flags got rv=%b le=%b exp 1 1", res_valid, len_err);
    end
    checks++;
    if (max_idx !== 4'd9 || max_val !== 16'sd8) begin
      errors++;
      $display("FAIL nolast_result got %0d/%0d exp 9/8", max_idx, max_val);
    end
    ack();
    checks++;
    if (len_err !== 1'b0) begin
      errors++;
      $display("FAIL nolast_clear got %b exp 0", len_err);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    load_mixed();
    send(10, 9);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 16'sd42;
    in_last   = 1'b0;
    res_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || res_valid !== 1'b1) bad++;
      if (max_idx !== 4'd2 || max_val !== 16'sd7) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stable got %0d bad cycles exp 0", bad);
    end
    ack();
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ack got rv=%b rdy=%b exp 0 1", res_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (max_val !== 16'sd42 || max_idx !== 4'd0) begin
      errors++;
      $display("FAIL bp_held_sample got %0d/%0d exp 0/42", max_idx, max_val);
    end
    reset = 1'b0;
    @(negedge clk);
    release_reset();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) vec[i] = 16'sd100;
    send(4, -1);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || max_val !== 16'sd0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async got rdy=%b val=%0d rv=%b exp 0 0 0", in_ready, max_val, res_valid);
    end
    @(negedge clk);
    release_reset();
    load_mixed();
    send(10, 9);
    checks++;
    if (max_idx !== 4'd2 || max_val !== 16'sd7 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_result got %0d/%0d/%b exp 2/7/0", max_idx, max_val, len_err);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_mixed();
    test_all_negative();
    test_extremes();
    test_short_last();
    test_no_last();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
